slt_arbiter: RTL

Shared set-less-than (SLT) compare resource for the 24-bit single-cycle CPU. Up to `NREQ` requesters (for example the branch unit, the ALU issue path and the debug port) compete for one 24-bit comparator. A round-robin arbiter picks one requester, a three-state FSM sequences the compare, and the result is returned over a valid/ready response channel tagged with the requester id. The block replaces per-requester comparators and sits beside the ALU in the execute stage.

---
 rtl/slt_pkg.sv | 28 ++
 rtl/slt_cmp.sv | 31 +++
 rtl/slt_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/slt_pkg.sv
// -----------------------------------------------------------------------------
// slt_pkg
// Shared definitions for the set-less-than compare resource.
//   state_e       : arbiter FSM states (IDLE, CMP, RESP)
//   SLT_WIDTH     : default operand width
//   SLT_NREQ_MAX  : largest supported requester count
//   slt_zext_bit  : widens a single compare result bit to the operand width
// -----------------------------------------------------------------------------
package slt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int SLT_WIDTH    = 24;
    localparam int SLT_NREQ_MAX = 8;

    // The SLT result is a boolean placed in bit 0 of a full-width word.
    function automatic logic [SLT_WIDTH-1:0] slt_zext_bit(input logic b);
        logic [SLT_WIDTH-1:0] r;
        r    = '0;
        r[0] = b;
        return r;
    endfunction

endpackage

// File: rtl/slt_cmp.sv
// -----------------------------------------------------------------------------
// slt_cmp
// Purely combinational WIDTH-bit less-than comparator.
// Ports:
//   a, b      in  WIDTH : operands
//   is_signed in  1     : 1 = two's-complement compare, 0 = unsigned
//   lt        out 1     : 1 when a < b (equal operands give 0)
// -----------------------------------------------------------------------------
module slt_cmp
    import slt_pkg::*;
#(
    parameter int WIDTH = SLT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             lt
);

    logic mag_lt;
    logic sign_diff;

    assign mag_lt    = (a < b);
    assign sign_diff = a[WIDTH-1] ^ b[WIDTH-1];

    // With differing signs the negative operand is the smaller one. With
    // matching signs two's-complement order equals plain unsigned order, so
    // the single magnitude compare serves both modes.
    assign lt = (is_signed && sign_diff) ? a[WIDTH-1] : mag_lt;

endmodule

// File: rtl/slt_arbiter.sv
// -----------------------------------------------------------------------------
// slt_arbiter
// Shared SLT compare resource: a round-robin arbiter grants one of NREQ
// requesters, a three-state FSM (IDLE -> CMP -> RESP) sequences one compare on
// a single shared comparator, and the result returns on a valid/ready channel
// tagged with the requester id.
//
// Ports:
//   Clock       in  1          : rising-edge clock
//   Reset       in  1          : asynchronous active-low reset
//   req_valid   in  NREQ       : per-requester request valid
//   req_ready   out NREQ       : accept strobe, one-hot or zero (combinational)
//   req_a       in  NREQ*WIDTH : operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       in  NREQ*WIDTH : operand B, same packing
//   req_signed  in  NREQ       : per-requester signed-compare select
//   rsp_valid   out 1          : result available (registered)
//   rsp_ready   in  1          : consumer accepts result
//   rsp_id      out IDW        : id of the requester owning the result
//   rsp_out     out WIDTH      : zero-extended A < B
//
// Build option: define SLT_ARB_SIGNED_EN to honour req_signed. Without it all
// compares are unsigned and req_signed is ignored.
// -----------------------------------------------------------------------------
module slt_arbiter
    import slt_pkg::*;
#(
    parameter int WIDTH = SLT_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_signed,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_out
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic             accept;
    logic             cmp_lt;
    logic             sgn_q;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

    assign accept = (state_q == IDLE) && gnt_found;

`ifdef SLT_ARB_SIGNED_EN
    always_ff @(posedge Clock) begin
        if (accept) begin
            sgn_q <= req_signed[gnt_id];
        end
    end
`else
    logic unused_req_signed;
    assign unused_req_signed = ^req_signed;
    assign sgn_q             = 1'b0;
`endif

    slt_cmp #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a         (a_q),
        .b         (b_q),
        .is_signed (sgn_q),
        .lt        (cmp_lt)
    );

    // FSM next-state and outputs.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        req_ready   = '0;

        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    // Ready is held low while reset is asserted so the
                    // outputs are all zero throughout reset.
                    req_ready[gnt_id] = Reset;
                    a_d      = req_a[int'(gnt_id)*WIDTH +: WIDTH];
                    b_d      = req_b[int'(gnt_id)*WIDTH +: WIDTH];
                    id_d     = gnt_id;
                    rr_ptr_d = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
                    state_d  = CMP;
                end
            end
            CMP: begin
                rsp_out_d   = {{(WIDTH-1){1'b0}}, cmp_lt};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
        end
    end

    // Latched operands are only consumed in CMP, which always follows an
    // accept, so they need no reset.
    always_ff @(posedge Clock) begin
        a_q  <= a_d;
        b_q  <= b_d;
        id_q <= id_d;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;

endmodule
